conv_pool_top: RTL and testbench

//  Streaming CNN front-end: 3x3 convolution over a zero-padded SIZE x SIZE frame
//  (SIZE = IMG + 2*PAD), then 2x2 stride-2 max pooling.

---
 rtl/conv_pool_top_if.sv | 21 ++
 rtl/conv_pool_top.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_pool_top.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_top_if.sv
// ---------------------------------------------------------------------------
// conv_pool_top_if
// Groups the streaming signals between the image loader / FC stage and the
// conv_pool_top engine.
//   w_load       loader -> engine  pulse: latch the ROM kernel
//   i_load       loader -> engine  frame start (capture begins when it drops)
//   img_in       loader -> engine  signed 16b pixel, each word held 2 cycles
//   pooling_out  engine -> FC      signed 16b pooled result
//   done_pooling engine -> FC      one-cycle strobe per pooled result
// modport master: the loader/testbench side; modport slave: the engine side.
// ---------------------------------------------------------------------------
interface conv_pool_top_if;
    logic               w_load;
    logic               i_load;
    logic signed [15:0] img_in;
    logic signed [15:0] pooling_out;
    logic               done_pooling;

    modport master (output w_load, i_load, img_in, input pooling_out, done_pooling);
    modport slave  (input w_load, i_load, img_in, output pooling_out, done_pooling);
endinterface

// File: rtl/conv_pool_top.sv
// ---------------------------------------------------------------------------
// conv_pool_top
// Streaming CNN front-end: captures a zero-padded SIZE x SIZE frame
// (SIZE = IMG + 2*PAD), runs a 3x3 convolution with a ROM kernel
// (w[r][c] = 3r+c+1) and 2x2 stride-2 max pooling, emitting (IMG/2)^2
// pooled words row-major, each with a one-cycle done_pooling strobe.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous ACTIVE-HIGH reset (legacy name)
//   bus    conv_pool_top_if.slave: w_load, i_load, img_in in;
//          pooling_out, done_pooling out
//
// Build option
//   CONV_RELU_EN  when defined, each saturated conv value is clamped to
//                 max(0,x) before pooling; otherwise raw signed values pool.
//
// Compute engine: one frame-buffer read per cycle, 9 MAC cycles per conv
// value, 4 conv values per pooled word. Pipeline: address issue -> RAM read
// -> MAC/saturate -> running max / output register.
// ---------------------------------------------------------------------------
module conv_pool_top #(
    parameter int IMG = 14,
    parameter int PAD = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_pool_top_if.slave bus
);
    localparam int SIZE  = IMG + 2 * PAD;
    localparam int DEPTH = SIZE * SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = IMG / 2;
    localparam int CW    = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_POS  = CW'(PW - 1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, COMPUTE} state_t;
    state_t state_reg;

    // Frame buffer. Not reset: every entry is rewritten by a full capture
    // before any compute reads it, so stale contents are never observable.
    logic signed [15:0] mem [DEPTH];
    logic signed [15:0] rd_data_reg;
    logic [AW-1:0]      rd_addr, wr_addr, cap_addr_reg;
    logic               wr_en, phase_reg;

    logic signed [15:0] w_tap [9];

    // Address-issue counters: pooled (p,q), conv sub-position, kernel tap.
    logic          issue_reg;
    logic [CW-1:0] p_reg, q_reg;
    logic [1:0]    sub_reg, a_reg, b_reg;

    // MAC stage
    logic               rd_vld_reg, s1_first_sub_reg, s1_last_sub_reg, s1_last_pool_reg;
    logic [3:0]         tap_reg;
    logic signed [35:0] acc_reg;

    // Pooling stage
    logic               conv_vld_reg, conv_first_sub_reg, conv_last_sub_reg, conv_last_pool_reg;
    logic signed [15:0] conv_reg, max_reg, pool_out_reg;
    logic               done_reg;

    logic signed [31:0] prod;
    logic signed [35:0] acc_sum;
    logic signed [15:0] conv_sat, conv_act, pool_max;
    int                 row_i, col_i;

    // Kernel registers: cleared by reset, loaded from the ROM rule in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_w
            logic signed [15:0] w_q;
            always_ff @(posedge clk) begin
                if (rst_n)
                    w_q <= '0;
                else if (state_reg == IDLE && bus.w_load)
                    w_q <= 16'(gi + 1);
            end
            assign w_tap[gi] = w_q;
        end
    endgenerate

    // Sample 0 is written on the ARM->CAPTURE edge; later samples every
    // second edge while phase_reg is set.
    always_comb begin
        row_i   = 2 * int'(p_reg) + int'(sub_reg[1]) + int'(a_reg);
        col_i   = 2 * int'(q_reg) + int'(sub_reg[0]) + int'(b_reg);
        rd_addr = AW'(row_i * SIZE + col_i);
        wr_en   = (state_reg == ARM && !bus.i_load) || (state_reg == CAPTURE && phase_reg);
        wr_addr = (state_reg == ARM) ? '0 : cap_addr_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= bus.img_in;
        rd_data_reg <= mem[rd_addr];
    end

    always_comb begin
        prod    = rd_data_reg * w_tap[tap_reg];
        acc_sum = ((tap_reg == 4'd0) ? 36'sd0 : acc_reg) + 36'(prod);
        if (acc_sum > 36'sd32767)
            conv_sat = 16'sh7fff;
        else if (acc_sum < -36'sd32768)
            conv_sat = 16'sh8000;
        else
            conv_sat = acc_sum[15:0];
`ifdef CONV_RELU_EN
        conv_act = conv_sat[15] ? 16'sd0 : conv_sat;
`else
        conv_act = conv_sat;
`endif
        pool_max = (conv_first_sub_reg || conv_reg > max_reg) ? conv_reg : max_reg;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg          <= IDLE;
            cap_addr_reg       <= '0;
            phase_reg          <= 1'b0;
            issue_reg          <= 1'b0;
            p_reg              <= '0;
            q_reg              <= '0;
            sub_reg            <= '0;
            a_reg              <= '0;
            b_reg              <= '0;
            rd_vld_reg         <= 1'b0;
            tap_reg            <= '0;
            s1_first_sub_reg   <= 1'b0;
            s1_last_sub_reg    <= 1'b0;
            s1_last_pool_reg   <= 1'b0;
            acc_reg            <= '0;
            conv_vld_reg       <= 1'b0;
            conv_reg           <= '0;
            conv_first_sub_reg <= 1'b0;
            conv_last_sub_reg  <= 1'b0;
            conv_last_pool_reg <= 1'b0;
            max_reg            <= '0;
            pool_out_reg       <= '0;
            done_reg           <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: if (bus.i_load) state_reg <= ARM;
                ARM: begin
                    if (!bus.i_load) begin
                        state_reg    <= CAPTURE;
                        cap_addr_reg <= AW'(1);
                        phase_reg    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    phase_reg <= ~phase_reg;
                    if (phase_reg) begin
                        cap_addr_reg <= cap_addr_reg + AW'(1);
                        if (cap_addr_reg == LAST_ADDR) begin
                            state_reg <= COMPUTE;
                            issue_reg <= 1'b1;
                            p_reg     <= '0;
                            q_reg     <= '0;
                            sub_reg   <= '0;
                            a_reg     <= '0;
                            b_reg     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (conv_vld_reg && conv_last_sub_reg && conv_last_pool_reg)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Nested counters: b fastest, then a, sub-position, q, p.
            if (issue_reg) begin
                if (b_reg != 2'd2) begin
                    b_reg <= b_reg + 2'd1;
                end else begin
                    b_reg <= '0;
                    if (a_reg != 2'd2) begin
                        a_reg <= a_reg + 2'd1;
                    end else begin
                        a_reg   <= '0;
                        sub_reg <= sub_reg + 2'd1;
                        if (sub_reg == 2'd3) begin
                            if (q_reg != LAST_POS) begin
                                q_reg <= q_reg + CW'(1);
                            end else begin
                                q_reg <= '0;
                                if (p_reg != LAST_POS) begin
                                    p_reg <= p_reg + CW'(1);
                                end else begin
                                    p_reg     <= '0;
                                    issue_reg <= 1'b0;
                                end
                            end
                        end
                    end
                end
            end

            // Tags travel alongside the registered RAM read.
            rd_vld_reg       <= issue_reg;
            tap_reg          <= 4'(a_reg) * 4'd3 + 4'(b_reg);
            s1_first_sub_reg <= (sub_reg == 2'd0);
            s1_last_sub_reg  <= (sub_reg == 2'd3);
            s1_last_pool_reg <= (p_reg == LAST_POS) && (q_reg == LAST_POS);

            conv_vld_reg <= 1'b0;
            if (rd_vld_reg) begin
                acc_reg <= acc_sum;
                if (tap_reg == 4'd8) begin
                    conv_vld_reg       <= 1'b1;
                    conv_reg           <= conv_act;
                    conv_first_sub_reg <= s1_first_sub_reg;
                    conv_last_sub_reg  <= s1_last_sub_reg;
                    conv_last_pool_reg <= s1_last_pool_reg;
                end
            end

            if (conv_vld_reg) begin
                max_reg <= pool_max;
                if (conv_last_sub_reg) begin
                    pool_out_reg <= pool_max;
                    done_reg     <= 1'b1;
                end
            end
        end
    end

    assign bus.pooling_out  = pool_out_reg;
    assign bus.done_pooling = done_reg;
endmodule

// File: tb/tb_conv_pool_top.sv
`timescale 1ns/1ps
module tb_conv_pool_top;
    localparam int IMG  = 14;
    localparam int PAD  = 1;
    localparam int SIZE = IMG + 2 * PAD;
    localparam int NPIX = SIZE * SIZE;
    localparam int PW   = IMG / 2;
    localparam int NOUT = PW * PW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_pool_top_if bus();

    conv_pool_top #(.IMG(IMG), .PAD(PAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int                 checks = 0;
    int                 errors = 0;
    logic signed [15:0] exp_q[$];
    int                 pix[NPIX];
    bit                 wl_model;
    int                 frame_strobes;
    bit                 seen_reset;
    logic signed [15:0] last_out;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: direct evaluation of the conv / saturate / pool definition.
    task automatic push_expected();
        for (int p = 0; p < PW; p++) begin
            for (int q = 0; q < PW; q++) begin
                longint best = 0;
                for (int d = 0; d < 4; d++) begin
                    int     i = 2 * p + d / 2;
                    int     j = 2 * q + d % 2;
                    longint s = 0;
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            s += longint'(wl_model ? (3 * a + b + 1) : 0) * pix[(i + a) * SIZE + j + b];
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
                    if (s < 0) s = 0;
`endif
                    if (d == 0 || s > best) best = s;
                end
                exp_q.push_back(16'(best));
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                seen_reset = 1'b1;
                last_out   = '0;
            end else if (seen_reset) begin
                if (bus.done_pooling === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got value %0d, expected no strobe", bus.pooling_out);
                    end else begin
                        logic signed [15:0] e;
                        e = exp_q.pop_front();
                        $display("out[%0d] = %0d (exp %0d)", frame_strobes, bus.pooling_out, e);
                        check($sformatf("pool[%0d]", frame_strobes), bus.pooling_out, e);
                    end
                    frame_strobes++;
                    last_out = bus.pooling_out;
                end else begin
                    check("hold_between_strobes", bus.pooling_out, last_out);
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n      = 1'b1;
        bus.i_load = 1'b0;
        bus.w_load = 1'b0;
        tick(n);
        rst_n    = 1'b0;
        wl_model = 1'b0;
    endtask

    task automatic do_wload();
        bus.w_load = 1'b1;
        tick(1);
        bus.w_load = 1'b0;
        wl_model   = 1'b1;
    endtask

    // abort_at < 0: full frame; otherwise stop before sample abort_at.
    // wl_hold drives w_load high through the capture, where it must be ignored.
    task automatic send_frame(input int abort_at, input bit wl_hold);
        frame_strobes = 0;
        if (abort_at < 0) push_expected();
        bus.i_load = 1'b1;
        tick(3);
        bus.i_load = 1'b0;
        for (int n = 0; n < NPIX; n++) begin
            if (n == abort_at) break;
            bus.img_in = 16'(pix[n]);
            if (n >= 1) bus.w_load = wl_hold;
            tick(2);
        end
        bus.w_load = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int extra);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 6000) begin
            tick(1);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d outputs missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(extra);
        check({name, "_strobes"}, frame_strobes, NOUT);
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < NPIX; n++) pix[n] = n;
    endtask

    task automatic fill_const(input int v);
        for (int n = 0; n < NPIX; n++) pix[n] = v;
    endtask

    task automatic fill_random(input bit full);
        for (int n = 0; n < NPIX; n++) begin
            logic signed [15:0] r;
            r = full ? 16'($urandom) : 16'($urandom_range(400) - 200);
            pix[n] = r;
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.i_load    = 1'b0;
        bus.w_load    = 1'b0;
        bus.img_in    = '0;
        wl_model      = 1'b0;
        frame_strobes = 0;
        seen_reset    = 1'b0;
        last_out      = '0;
        fork
            monitor();
        join_none

        // 1: reset state, weight load, ramp frame
        do_reset(4);
        check("reset_pooling_out", bus.pooling_out, 0);
        check("reset_done_pooling", 64'(bus.done_pooling), 0);
        do_wload();
        fill_ramp();
        send_frame(-1, 1'b0);
        wait_frame("ramp", 20);

        // 2: weights cleared by reset; w_load during capture is ignored
        do_reset(4);
        send_frame(-1, 1'b1);
        wait_frame("no_weights", 20);

        // 3, 4: constant frames (negative, saturating)
        do_wload();
        fill_const(-1);
        send_frame(-1, 1'b0);
        wait_frame("all_minus1", 20);
        fill_const(32767);
        send_frame(-1, 1'b0);
        wait_frame("all_max", 20);

        // 5: reset mid-capture abandons the frame and clears weights
        fill_ramp();
        send_frame(101, 1'b0);
        do_reset(2);
        frame_strobes = 0;
        tick(3000);
        check("abort_no_strobe", frame_strobes, 0);
        check("abort_pooling_out", bus.pooling_out, 0);
        send_frame(-1, 1'b0);
        wait_frame("after_abort", 20);

        // 6: back-to-back frames
        do_wload();
        send_frame(-1, 1'b0);
        wait_frame("b2b_first", 0);
        for (int n = 0; n < NPIX; n++) pix[n] = 255 - n;
        send_frame(-1, 1'b0);
        wait_frame("b2b_second", 20);

        // randomized frames
        for (int k = 0; k < 4; k++) begin
            fill_random(k[0]);
            tick($urandom_range(5));
            send_frame(-1, 1'b0);
            wait_frame($sformatf("random%0d", k), 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
